// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one synchronous sprite/tile ROM port among N_REQ requesters.
// Define SPRITE_ARB_FIXED_PRIO_EN to replace round-robin with fixed lowest-index priority.
module sprite_rom_arbiter #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned ADDR_W  = 12,
    parameter int unsigned DATA_W  = 24,
    parameter int unsigned ROM_LAT = 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_en,
    input  logic [N_REQ-1:0]        i_req,
    input  logic [N_REQ*ADDR_W-1:0] i_addr,
    output logic [N_REQ-1:0]        o_gnt,
    output logic                    o_rom_en,
    output logic [ADDR_W-1:0]       o_rom_addr,
    input  logic [DATA_W-1:0]       i_rom_data,
    output logic [DATA_W-1:0]       o_rdata,
    output logic [N_REQ-1:0]        o_rvalid,
    input  logic                    i_clr,
    output logic [15:0]             o_conflicts
);

    localparam int unsigned IDX_W = $clog2(N_REQ);

    if (N_REQ < 2 || N_REQ > 8) begin : g_chk_nreq
        $error("sprite_rom_arbiter: N_REQ must be in 2..8");
    end
    if (ROM_LAT < 1 || ROM_LAT > 3) begin : g_chk_lat
        $error("sprite_rom_arbiter: ROM_LAT must be in 1..3");
    end

    logic                          gnt_any;
    logic [IDX_W-1:0]              gnt_idx;
    logic [3:0]                    req_cnt;
    logic                          contended;

    logic [ROM_LAT:0]              tag_vld_q, tag_vld_d;
    logic [ROM_LAT:0][IDX_W-1:0]   tag_idx_q, tag_idx_d;
    logic [ADDR_W-1:0]             rom_addr_q, rom_addr_d;
    logic [DATA_W-1:0]             rdata_q, rdata_d;
    logic [N_REQ-1:0]              rvalid_q, rvalid_d;
    logic [15:0]                   conflicts_q, conflicts_d;

`ifdef SPRITE_ARB_FIXED_PRIO_EN
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        if (i_rst && i_en) begin
            // Descending scan so the lowest requesting index is the last write.
            for (int unsigned i = N_REQ; i > 0; i--) begin
                if (i_req[i-1]) begin
                    gnt_any = 1'b1;
                    gnt_idx = IDX_W'(i - 1);
                end
            end
        end
    end
`else
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0] cand;

    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        if (i_rst && i_en) begin
            for (int unsigned i = 0; i < N_REQ; i++) begin
                cand = IDX_W'((32'(rr_ptr_q) + i) % N_REQ);
                if (!gnt_any && i_req[cand]) begin
                    gnt_any = 1'b1;
                    gnt_idx = cand;
                end
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (gnt_any) begin
            rr_ptr_d = (gnt_idx == IDX_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`endif

    assign o_gnt = gnt_any ? (N_REQ'(1) << gnt_idx) : '0;

    always_comb begin
        req_cnt = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            req_cnt = req_cnt + 4'(i_req[i]);
        end
        contended = i_en && (req_cnt >= 4'd2);
    end

    always_comb begin
        tag_vld_d  = {tag_vld_q[ROM_LAT-1:0], gnt_any};
        tag_idx_d  = {tag_idx_q[ROM_LAT-1:0], gnt_idx};
        rom_addr_d = gnt_any ? i_addr[gnt_idx*ADDR_W +: ADDR_W] : rom_addr_q;
        // Last tag stage lines up with the cycle the ROM word is valid.
        rdata_d    = tag_vld_q[ROM_LAT] ? i_rom_data : rdata_q;
        rvalid_d   = tag_vld_q[ROM_LAT] ? (N_REQ'(1) << tag_idx_q[ROM_LAT]) : '0;

        conflicts_d = conflicts_q;
        if (i_clr) begin
            conflicts_d = '0;
        end else if (contended && conflicts_q != '1) begin
            conflicts_d = conflicts_q + 16'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            tag_vld_q   <= '0;
            tag_idx_q   <= '0;
            rom_addr_q  <= '0;
            rdata_q     <= '0;
            rvalid_q    <= '0;
            conflicts_q <= '0;
        end else begin
            tag_vld_q   <= tag_vld_d;
            tag_idx_q   <= tag_idx_d;
            rom_addr_q  <= rom_addr_d;
            rdata_q     <= rdata_d;
            rvalid_q    <= rvalid_d;
            conflicts_q <= conflicts_d;
        end
    end

    assign o_rom_en    = tag_vld_q[0];
    assign o_rom_addr  = rom_addr_q;
    assign o_rdata     = rdata_q;
    assign o_rvalid    = rvalid_q;
    assign o_conflicts = conflicts_q;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Scoreboard bench for sprite_rom_arbiter: directed scenarios plus randomized traffic,
// checked against a distance-based arbitration model and an expected-return queue.
module tb_sprite_rom_arbiter;

    localparam int N       = 4;
    localparam int ADDR_W  = 12;
    localparam int DATA_W  = 24;
    localparam int ROM_LAT = 1;

    typedef struct {
        int                due;
        int                idx;
        logic [DATA_W-1:0] data;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                en;
    logic [N-1:0]        req;
    logic [N*ADDR_W-1:0] addr;
    logic [N-1:0]        gnt;
    logic                rom_en;
    logic [ADDR_W-1:0]   rom_addr;
    logic [DATA_W-1:0]   rom_data;
    logic [DATA_W-1:0]   rdata;
    logic [N-1:0]        rvalid;
    logic                clr;
    logic [15:0]         conflicts;

    logic [DATA_W-1:0]   rom_pipe [ROM_LAT];

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    exp_t sb[$];

    int                m_ptr  = 0;
    int                m_cnt  = 0;
    logic              m_en   = 1'b0;
    logic [ADDR_W-1:0] m_addr = '0;

    sprite_rom_arbiter #(
        .N_REQ   (N),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .ROM_LAT (ROM_LAT)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst_n),
        .i_en        (en),
        .i_req       (req),
        .i_addr      (addr),
        .o_gnt       (gnt),
        .o_rom_en    (rom_en),
        .o_rom_addr  (rom_addr),
        .i_rom_data  (rom_data),
        .o_rdata     (rdata),
        .o_rvalid    (rvalid),
        .i_clr       (clr),
        .o_conflicts (conflicts)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [DATA_W-1:0] rom_f(input logic [ADDR_W-1:0] a);
        return {a ^ 12'h5A3, a};
    endfunction

    // Synchronous ROM with ROM_LAT cycles from sampled address to data.
    always @(posedge clk) begin
        rom_pipe[0] <= rom_f(rom_addr);
        for (int k = 1; k < ROM_LAT; k++) rom_pipe[k] <= rom_pipe[k-1];
    end
    assign rom_data = rom_pipe[ROM_LAT-1];

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endfunction

    // Reference model: winner is the requester closest (mod N) at or after the pointer.
    always @(negedge clk) begin
        logic [N-1:0]      eg;
        logic [ADDR_W-1:0] ga;
        int                gi, best, d;
        if (!rst_n) begin
            chk("rst_gnt", 32'(gnt), 0);
            chk("rst_rom_en", 32'(rom_en), 0);
            chk("rst_rom_addr", 32'(rom_addr), 0);
            chk("rst_rdata", 32'(rdata), 0);
            chk("rst_rvalid", 32'(rvalid), 0);
            chk("rst_conflicts", 32'(conflicts), 0);
            m_ptr = 0; m_cnt = 0; m_en = 1'b0; m_addr = '0;
        end else begin
            eg = '0; gi = -1; best = N;
            if (en) begin
                for (int k = 0; k < N; k++) begin
                    if (req[k]) begin
                        d = (k - m_ptr + N) % N;
                        if (d < best) begin best = d; gi = k; end
                    end
                end
            end
            if (gi >= 0) eg[gi] = 1'b1;
            chk("gnt", 32'(gnt), 32'(eg));
            chk("rom_en", 32'(rom_en), 32'(m_en));
            chk("rom_addr", 32'(rom_addr), 32'(m_addr));
            chk("conflicts", 32'(conflicts), 32'(m_cnt));
            if (gi >= 0) begin
                ga = addr[gi*ADDR_W +: ADDR_W];
                sb.push_back('{due: cyc + ROM_LAT + 2, idx: gi, data: rom_f(ga)});
                m_addr = ga;
                m_en   = 1'b1;
`ifndef SPRITE_ARB_FIXED_PRIO_EN
                m_ptr  = (gi + 1) % N;
`endif
            end else begin
                m_en = 1'b0;
            end
            if (clr) m_cnt = 0;
            else if (en && $countones(req) >= 2 && m_cnt < 65535) m_cnt++;
        end
    end

    // Return monitor: pops the expected read whenever the DUT presents one.
    always @(negedge clk) begin
        exp_t         e;
        logic [N-1:0] ev;
        if (rvalid != '0) begin
            if (sb.size() == 0) begin
                chk("rvalid_unexpected", 32'(rvalid), 0);
            end else begin
                e  = sb.pop_front();
                ev = '0;
                ev[e.idx] = 1'b1;
                chk("rvalid", 32'(rvalid), 32'(ev));
                chk("rdata", 32'(rdata), 32'(e.data));
                chk("rvalid_cycle", 32'(cyc), 32'(e.due));
            end
        end else if (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            chk("rvalid_missing", 32'(rvalid), 32'(1 << e.idx));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input int k, input logic [ADDR_W-1:0] a);
        addr[k*ADDR_W +: ADDR_W] = a;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        sb.delete();
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [N-1:0] g;
        rst_n = 1'b0; en = 1'b1; req = '0; addr = '0; clr = 1'b0;
        do_reset();
        step();

        // Single requester
        req = 4'b0001; set_addr(0, 12'h123);
        step();
        req = '0;
        repeat (4) step();

        // All four from reset for 8 cycles
        do_reset();
        for (int k = 0; k < N; k++) set_addr(k, ADDR_W'(12'h200 + k));
        req = 4'b1111;
        repeat (8) step();
        req = '0;
        @(negedge clk);
        chk("conflicts_after_8", 32'(conflicts), 8);
        step();
        repeat (3) step();

        // Move pointer to 2, then requesters 1 and 3 with an enable gap
        req = 4'b0010; set_addr(1, 12'h0AA);
        step();
        req = 4'b1010; set_addr(3, 12'h0BB);
        repeat (4) step();
        en = 1'b0;
        repeat (3) step();
        en = 1'b1;
        repeat (2) step();
        req = '0;
        repeat (4) step();

        // Clear wins over a coincident increment
        do_reset();
        req = 4'b1111;
        repeat (5) step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        @(negedge clk);
        chk("conflicts_clr", 32'(conflicts), 0);
        step();

        // Saturation
        repeat (65540) step();
        @(negedge clk);
        chk("conflicts_sat", 32'(conflicts), 32'hFFFF);
        step();
        clr = 1'b1; req = '0;
        step();
        clr = 1'b0;
        repeat (4) step();

        // Reset one cycle after a grant
        req = 4'b0001; set_addr(0, 12'h3AB);
        step();
        req = '0;
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("async_rst_rom_en", 32'(rom_en), 0);
        chk("async_rst_rom_addr", 32'(rom_addr), 0);
        chk("async_rst_rdata", 32'(rdata), 0);
        chk("async_rst_rvalid", 32'(rvalid), 0);
        chk("async_rst_conflicts", 32'(conflicts), 0);
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("post_rst_rvalid", 32'(rvalid), 0);
            step();
        end

        // Randomized traffic obeying the hold-until-granted handshake
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            g = gnt;
            @(posedge clk);
            #1;
            for (int k = 0; k < N; k++) begin
                if (!req[k] || g[k]) begin
                    req[k] = ($urandom_range(0, 3) != 0);
                    set_addr(k, ADDR_W'($urandom()));
                end
            end
            en  = ($urandom_range(0, 7) != 0);
            clr = ($urandom_range(0, 31) == 0);
        end
        req = '0; clr = 1'b0; en = 1'b1;
        repeat (ROM_LAT + 4) step();
        chk("sb_drain", 32'(sb.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sprite_rom_arbiter.md
# sprite_rom_arbiter

Shares one synchronous sprite/tile ROM read port among up to `N_REQ` pixel-pipeline requesters, such as the player sprite, the maze map and the ghost sprites. It issues at most one ROM read per cycle using round-robin arbitration and returns the read data to the granted requester with fixed latency. It also gates new reads with a display-enable and counts contention cycles for tuning the sprite pipeline. It sits between the sprite renderers and the shared ROM, upstream of the video layer arbiter.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters, 2..8
- `ADDR_W`, 12: ROM address width
- `DATA_W`, 24: ROM word width (one `rgb_t`)
- `ROM_LAT`, 1: ROM read latency in cycles, from `o_rom_en` sampled to `i_rom_data` valid; 1..3

Ports:
- `i_clk`  in  1  sole clock; all logic on the rising edge
- `i_rst`  in  1  reset, asynchronous assert, active-low
- `i_en`  in  1  grant enable; low during blanking
- `i_req`  in  N_REQ  per-requester read request, level
- `i_addr`  in  N_REQ×ADDR_W  per-requester address, packed, requester k at `[k*ADDR_W +: ADDR_W]`
- `o_gnt`  out  N_REQ  one-hot grant, combinational, same cycle as request
- `o_rom_en`  out  1  ROM read strobe, registered
- `o_rom_addr`  out  ADDR_W  ROM address, registered
- `i_rom_data`  in  DATA_W  ROM read data
- `o_rdata`  out  DATA_W  returned data, registered
- `o_rvalid`  out  N_REQ  one-hot: `o_rdata` belongs to requester k
- `i_clr`  in  1  clear contention counter
- `o_conflicts`  out  16  count of cycles with ≥2 requests while enabled, saturating

## Operation
- Reset (`i_rst`=0): `o_gnt`=0, `o_rom_en`=0, `o_rom_addr`=0, `o_rdata`=0, `o_rvalid`=0, `o_conflicts`=0, RR pointer=0, tag pipeline cleared.
- Arbitration, combinational each cycle: if `i_en`=1 and `i_req`≠0, grant the first requesting index found searching from the RR pointer upward, wrapping at `N_REQ`-1 → 0. `o_gnt` is one-hot, or 0 if disabled or no request.
- RR pointer becomes (granted index + 1) mod `N_REQ` on a grant. Unchanged when no grant.
- Handshake: requester holds `i_req`=1 and a stable `i_addr` until it sees `o_gnt[k]`=1. It may drop or re-assert with a new address in the next cycle. Each grant is exactly one read; a held request is re-arbitrated normally.
- Grant pipeline: a granted index and address register into `o_rom_addr`/`o_rom_en`. The index travels through a tag shift register of depth `ROM_LAT`+1. When the tag emerges, `o_rdata`←`i_rom_data` and `o_rvalid[tag]`=1 for one cycle.
- `i_en` low: no new grants; in-flight reads still complete and return.
- Contention: `o_conflicts` increments when `i_en`=1 and popcount(`i_req`)≥2. It saturates at 0xFFFF. `i_clr`=1 forces it to 0; if `i_clr` coincides with an increment, clear wins and the result is 0.
- `N_REQ`=1 illegal; out-of-range parameters are an elaboration error.

## Timing
- Grant in cycle T. `o_rom_en`/`o_rom_addr` valid in T+1. `i_rom_data` valid in T+1+`ROM_LAT`. `o_rvalid`/`o_rdata` valid in T+2+`ROM_LAT`; the default is T+3.
- Throughput: one read per cycle, back-to-back, with no bubbles between different or the same requesters.
- `o_rom_en`=0 whenever no grant occurred in the prior cycle; `o_rom_addr` holds its last value.
- Reset asserted mid-operation: all in-flight reads are discarded. After release, no `o_rvalid` appears until a new grant is followed by the full latency.
- Fairness: a continuously requesting requester is granted within `N_REQ` enabled cycles.

## Configuration
- `SPRITE_ARB_FIXED_PRIO_EN` defined: fixed priority replaces round-robin. The lowest index wins, and the RR pointer is neither implemented nor updated. The fairness bound no longer applies.
- Undefined (default): round-robin as specified above.

## Test plan
- Single requester: `i_req`=0001, `i_addr[0]`=0x123, `i_en`=1 → `o_gnt`=0001 at T. `o_rom_addr`=0x123 with `o_rom_en`=1 at T+1. `o_rvalid`=0001 with `o_rdata`=ROM[0x123] at T+3.
- All four held high for 8 cycles from reset → grant sequence 0,1,2,3,0,1,2,3. `o_rvalid` follows the same order 3 cycles later. `o_conflicts`=8.
- Requesters 1 and 3 held high, pointer at 2 → grants 3,1,3,1. `i_en` dropped mid-sequence → no grants while low; reads already issued still return.
- `i_clr` pulsed in a contended cycle with the counter at 5 → `o_conflicts`=0 next cycle. Force the counter to 0xFFFF and hold contention → it stays 0xFFFF.
- `i_rst` asserted one cycle after a grant → all outputs 0 immediately. After release with no requests, `o_rvalid` stays 0 for 10 cycles.
- With `SPRITE_ARB_FIXED_PRIO_EN`: `i_req`=1010 held → `o_gnt`=0010 every cycle; requester 3 is never granted.
